// File: rtl/gamate_audio_pkg.sv
// Shared constants and helpers for the Gamate audio/timer register block.
// The register addresses and mode masks match the CPU-visible map at $20/$21.
package gamate_audio_pkg;

    localparam logic [6:0]  REG_T0_DIV    = 7'h20;
    localparam logic [6:0]  REG_TIMER_INT = 7'h21;

    // Bits 0, 2, 8, A, C and E: the audio modes that never raise interrupt B.
    localparam logic [15:0] NO_IRQB_MODES = 16'h5505;

    localparam int MODE_W    = 4;
    localparam int PRESC_W   = 3;
    localparam int FREQ_W    = 12;
    localparam int T0_W      = 8;
    localparam int PRE_CNT_W = 7;

    typedef struct packed {
        logic base;
        logic sq1;
        logic sq2;
        logic noise;
    } strobe_t;

    function automatic logic mode_raises_irqb(input logic [MODE_W-1:0] mode);
        return ~NO_IRQB_MODES[mode];
    endfunction

    // Low 'sel' bits set: the prescaler fires when these counter bits are all ones.
    function automatic logic [PRE_CNT_W-1:0] presc_mask(input logic [PRESC_W-1:0] sel);
        logic [PRE_CNT_W-1:0] m;
        for (int i = 0; i < PRE_CNT_W; i++) begin
            m[i] = (i < int'(sel));
        end
        return m;
    endfunction

endpackage

// File: rtl/audio_period_ctr.sv
// Reloading down counter shared by the square channels and timer 0.
// A zero period halts the channel; load_i forces an immediate restart.
module audio_period_ctr #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] period_i,
    output logic         fire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // A force-load discards the count in progress and suppresses that tick.
    always_comb begin
        cnt_d  = cnt_q;
        fire_o = 1'b0;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i) begin
            if (period_i == '0) begin
                cnt_d = '0;
            end else if (cnt_q == '0) begin
                cnt_d  = period_i;
                fire_o = 1'b1;
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/audio_timer_sched.sv
// Audio tick scheduler and interrupt-B controller: base divider, prescaler,
// square/noise step strobes, timer 0 ($20) and timer interrupt control ($21).
module audio_timer_sched
    import gamate_audio_pkg::*;
#(
    parameter int BASE_DIV = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic                sys_cs,
    input  logic                cpu_rwn,
    input  logic [6:0]          AB,
    input  logic [7:0]          din,
    output logic [7:0]          dout,
    input  logic [MODE_W-1:0]   audio_mode,
    input  logic [PRESC_W-1:0]  prescaler,
    input  logic [FREQ_W-1:0]   sq1_freq,
    input  logic [FREQ_W-1:0]   sq2_freq,
    output logic                base_tick,
    output logic                sq1_step,
    output logic                sq2_step,
    output logic                noise_step,
    output logic                irq_b
);

    localparam int BASE_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(BASE_DIV - 1);

    logic [BASE_W-1:0]    base_cnt_q, base_cnt_d;
    logic [PRE_CNT_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PRE_CNT_W-1:0] pre_mask;
    logic [T0_W-1:0]      t0_div_q, t0_div_d;
    logic                 irq_en_q, irq_en_d;
    logic                 irq_pend_q, irq_pend_d;
    strobe_t              strobe_q, strobe_d;

    logic reg_wr;
    logic wr_t0_div;
    logic wr_timer_int;
    logic base_wrap;
    logic pre_tick;
    logic sq1_fire;
    logic sq2_fire;
    logic t0_event;

    // Every tick below is qualified by ce, so nothing moves while ce is low.
    always_comb begin
        reg_wr       = ce & sys_cs & ~cpu_rwn;
        wr_t0_div    = reg_wr & (AB == REG_T0_DIV);
        wr_timer_int = reg_wr & (AB == REG_TIMER_INT);

        base_wrap  = ce & (base_cnt_q == BASE_LAST);
        base_cnt_d = ce ? base_cnt_q + BASE_W'(1) : base_cnt_q;

        pre_mask  = presc_mask(prescaler);
        pre_tick  = base_wrap & ((pre_cnt_q & pre_mask) == pre_mask);
        pre_cnt_d = base_wrap ? pre_cnt_q + PRE_CNT_W'(1) : pre_cnt_q;
    end

    audio_period_ctr #(.W(FREQ_W)) u_sq1 (
        .clk        (clk),
        .reset      (reset),
        .tick_i     (pre_tick),
        .load_i     (1'b0),
        .load_val_i ('0),
        .period_i   (sq1_freq),
        .fire_o     (sq1_fire)
    );

    audio_period_ctr #(.W(FREQ_W)) u_sq2 (
        .clk        (clk),
        .reset      (reset),
        .tick_i     (pre_tick),
        .load_i     (1'b0),
        .load_val_i ('0),
        .period_i   (sq2_freq),
        .fire_o     (sq2_fire)
    );

    audio_period_ctr #(.W(T0_W)) u_t0 (
        .clk        (clk),
        .reset      (reset),
        .tick_i     (base_wrap),
        .load_i     (wr_t0_div),
        .load_val_i (din),
        .period_i   (t0_div_q),
        .fire_o     (t0_event)
    );

    // Pending is set after the clear is applied so a coincident timer event wins.
    always_comb begin
        t0_div_d   = wr_t0_div ? din : t0_div_q;
        irq_en_d   = wr_timer_int ? din[0] : irq_en_q;
        irq_pend_d = irq_pend_q;
        if (wr_timer_int && din[7]) begin
            irq_pend_d = 1'b0;
        end
        if (t0_event && mode_raises_irqb(audio_mode)) begin
            irq_pend_d = 1'b1;
        end

        strobe_d.base  = base_wrap;
        strobe_d.sq1   = sq1_fire;
        strobe_d.sq2   = sq2_fire & ~audio_mode[3];
        strobe_d.noise = sq2_fire &  audio_mode[3];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_cnt_q <= '0;
            pre_cnt_q  <= '0;
            t0_div_q   <= '0;
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            strobe_q   <= '0;
        end else begin
            base_cnt_q <= base_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            t0_div_q   <= t0_div_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            strobe_q   <= strobe_d;
        end
    end

    always_comb begin
        dout = 8'h00;
        if (sys_cs && cpu_rwn) begin
            case (AB)
                REG_T0_DIV:    dout = t0_div_q;
                REG_TIMER_INT: dout = {irq_pend_q, 6'b000000, irq_en_q};
                default:       dout = 8'h00;
            endcase
        end
    end

    assign base_tick  = strobe_q.base;
    assign sq1_step   = strobe_q.sq1;
    assign sq2_step   = strobe_q.sq2;
    assign noise_step = strobe_q.noise;
    assign irq_b      = irq_pend_q & irq_en_q;

endmodule

// File: doc/audio_timer_sched.md
# audio_timer_sched

Tick scheduler and interrupt-B controller for the Gamate audio/timer register block. Divides the CPU clock enable into the 128-cycle audio base tick and applies the `audio_ctl` prescaler. Runs the square 1 and square 2/noise period counters and emits one-cycle step strobes to the tone datapath. Owns timer 0 (`$20`) and timer interrupt control (`$21`), raising `irq_b` only in modes that generate interrupt B.

## Interface
Parameters:
- `BASE_DIV`, default 128: `ce` pulses per base tick; must be a power of two.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `ce`  in  1  CPU clock enable; all state advances only when `ce`=1.
- `sys_cs`  in  1  audio/timer register space select.
- `cpu_rwn`  in  1  1 = read, 0 = write.
- `AB`  in  7  register address.
- `din`  in  8  CPU write data.
- `dout`  out  8  read data; combinational; `$00` when not selected.
- `audio_mode`  in  4  `audio_ctl[3:0]` from the register block.
- `prescaler`  in  3  `audio_ctl[6:4]`.
- `sq1_freq`  in  12  square 1 period.
- `sq2_freq`  in  12  square 2 / noise period.
- `base_tick`  out  1  1-cycle strobe every `BASE_DIV` `ce` pulses.
- `sq1_step`  out  1  square 1 half-period strobe.
- `sq2_step`  out  1  square 2 half-period strobe, when `audio_mode[3]`=0.
- `noise_step`  out  1  noise LFSR advance strobe, when `audio_mode[3]`=1.
- `irq_b`  out  1  level interrupt B request (pending AND enable).

## Operation
- Register writes occur when `ce & sys_cs & ~cpu_rwn`.
- Base divider:
  - 7-bit up counter on `ce`.
  - `base_tick`=1 in the `ce` cycle where the counter wraps 127→0.
- Prescaler:
  - 7-bit counter of base ticks.
  - `pre_tick` fires on a base tick when counter bits `[prescaler-1:0]` are all ones; `prescaler`=0 means every base tick.
  - Period is therefore 2^`prescaler` base ticks.
- Square period counters (sq1, sq2), 12 bits each:
  - Decrement on `pre_tick`.
  - On a `pre_tick` while the counter is 0: reload from `freq` and strobe the step.
  - `freq`=0: channel halted, counter held at 0, no strobes.
  - A `freq` change takes effect at the next reload.
- `sq2` strobe routing:
  - `noise_step` when `audio_mode[3]`=1; otherwise `sq2_step`.
  - Never both.
- Timer 0:
  - Writing `$20` stores `t0_div` and reloads the 8-bit down counter immediately, discarding any count in progress.
  - The counter decrements on `base_tick`.
  - On a `base_tick` while the counter is 0: reload from `t0_div` and generate `t0_event`.
  - `t0_div`=0: timer stopped, no events.
- `$21` write:
  - `bit0` → `irq_en`.
  - `bit7`=1 clears `irq_pend`.
  - Other bits ignored.
- `$21` read returns {`irq_pend`, 6'b0, `irq_en`}.
- `$20` read returns `t0_div`.
- Setting `irq_pend`: on `t0_event` when `audio_mode` ∉ {0,2,8,A,C,E}.
- Simultaneous `t0_event` and clear write: set wins.
- `irq_b` = `irq_pend & irq_en`.

## Timing
- Reset values:
  - All counters 0; `t0_div`=0, `irq_en`=0, `irq_pend`=0.
  - All strobes 0, `irq_b`=0.
  - `dout` = `$00` unless a read is in progress.
- All strobes are exactly one `clk` cycle wide, coincident with a `ce` cycle, and registered.
- Each strobe asserts on the clock edge after the `ce` cycle in which its condition is met.
- `irq_b` rises one `clk` after `t0_event`.
- `irq_b` falls one `clk` after the clearing write or after `irq_en` is written to 0.
- Reset asserted mid-operation zeroes all state in the same edge; strobes issue no partial pulses.
- Counters do not move while `ce`=0; register writes still require `ce`=1.

## Structure
- Shared package `gamate_audio_pkg`:
  - Register address constants (`REG_T0_DIV`=`7'h20`, `REG_TIMER_INT`=`7'h21`).
  - 16-bit `NO_IRQB_MODES` mask (bits 0, 2, 8, A, C, E set).
  - Mode-field widths.
- One sub-module, `audio_period_ctr` (parameter `W`):
  - Load/decrement/zero-reload counter with halt-on-zero-period.
  - Instanced as sq1 (`W`=12), sq2 (`W`=12) and timer 0 (`W`=8, with force-load input).

## Test plan
- `ce` held high, reset released → `base_tick` every 128 `clk` cycles; no other strobes while `freq`=0.
- `prescaler`=2, `sq1_freq`=3 → first `sq1_step` at pre_tick 1, then every 4 pre_ticks (16 base ticks).
- `audio_mode`=`C`, `sq2_freq`=1 → `noise_step` every 2 base ticks, `sq2_step` stays 0; switching to mode 4 moves the strobes to `sq2_step`.
- Write `$20`=`$05`, `$21`=`$01`, mode 6 → `irq_b` rises after 6 base ticks. Write `$21`=`$81` → `irq_b` low next clock. Read `$21` → `$01`.
- Same setup in mode `A` → `irq_b` stays 0 over 100 base ticks.
- Clear write coincident with `t0_event` → `irq_pend` remains 1. Reset asserted mid-count → all outputs 0 the next cycle and the first `base_tick` 128 `ce` pulses later.
